itcm_arb: RTL and testbench

Two-requester arbiter that shares the single-port instruction TCM between the instruction-fetch stage and a data/loader port (load/store to ITCM, program load). It sits between `instruction`/`execution` and the `itcm` macro and drives the memory's enable, byte-write and address lines. It issues same-cycle grants, tracks which requester owns the one-cycle-latency read return, and enforces a bounded fetch wait so the pipeline cannot starve behind a data burst.

---
 rtl/itcm_arb_if.sv | 38 +++
 rtl/itcm_arb.sv | 95 +++++++++
 tb/tb_itcm_arb.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/itcm_arb_if.sv
// Bundle of the fetch, data and ITCM macro signals around itcm_arb.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface itcm_arb_if #(
    parameter int unsigned AW = 16
) ();
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;

    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;

    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/itcm_arb.sv
// Fetch/data arbiter for the single-port ITCM: same-cycle grants and one-cycle read return routing.
// Define ITCM_ARB_STARVE_EN to build the bounded fetch-wait (starvation) counter.
module itcm_arb #(
    parameter int unsigned AW         = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic       clk_i,
    input logic       rst_ni,
    itcm_arb_if.slave bus_io
);

    typedef enum logic [1:0] {OwnNone, OwnIf, OwnD} owner_e;

    owner_e owner_q, owner_d;
    logic   if_gnt, d_gnt;
    logic   starve_hit;

`ifdef ITCM_ARB_STARVE_EN
    logic [3:0] starve_q, starve_d;

    assign starve_hit = (starve_q == 4'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (!bus_io.if_req || if_gnt) begin
            starve_d = 4'd0;
        end else if (starve_q < 4'(STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic [3:0] unused_starve_max;

    assign unused_starve_max = 4'(STARVE_MAX);
    assign starve_hit        = 1'b0;
`endif

    // Data wins by default; grants are held off for the whole time reset is low.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst_ni) begin
            if (bus_io.if_req && (!bus_io.d_req || starve_hit)) begin
                if_gnt = 1'b1;
            end else if (bus_io.d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    assign bus_io.if_gnt    = if_gnt;
    assign bus_io.d_gnt     = d_gnt;
    assign bus_io.mem_en    = if_gnt | d_gnt;
    assign bus_io.mem_we    = (d_gnt && bus_io.d_we) ? bus_io.d_be : 4'b0000;
    assign bus_io.mem_addr  = d_gnt ? bus_io.d_addr[AW-1:2] : bus_io.if_addr[AW-1:2];
    assign bus_io.mem_wdata = bus_io.d_wdata;
    assign bus_io.if_rdata  = bus_io.mem_rdata;
    assign bus_io.d_rdata   = bus_io.mem_rdata;

    logic [3:0] unused_addr_lsb;
    assign unused_addr_lsb = {bus_io.if_addr[1:0], bus_io.d_addr[1:0]};

    // Read-return owner: state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OwnNone;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Writes produce no return, so they leave the owner at none.
    always_comb begin
        owner_d = OwnNone;
        if (if_gnt) begin
            owner_d = OwnIf;
        end else if (d_gnt && !bus_io.d_we) begin
            owner_d = OwnD;
        end
    end

    always_comb begin
        bus_io.if_rvalid = (owner_q == OwnIf);
        bus_io.d_rvalid  = (owner_q == OwnD);
    end

endmodule

// File: tb/tb_itcm_arb.sv
// Self-checking bench for itcm_arb: directed scenarios with literal expectations, then random
// traffic checked every cycle against a priority/return/memory reference model.
module tb_itcm_arb;
    localparam int unsigned AW        = 16;
    localparam int unsigned StarveMax = 4;
    localparam int unsigned MemWords  = 1 << (AW - 2);
`ifdef ITCM_ARB_STARVE_EN
    localparam bit StarveEn      = 1'b1;
    localparam int ExpFirstIf    = 5;
    localparam int ExpIfGrants   = 4;
`else
    localparam bit StarveEn      = 1'b0;
    localparam int ExpFirstIf    = 0;
    localparam int ExpIfGrants   = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    itcm_arb_if #(.AW(AW)) bus ();

    itcm_arb #(.AW(AW), .STARVE_MAX(StarveMax)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] preload(input int unsigned w);
        if (w == 32'h50) return 32'h1122_3344;
        return 32'h1000_0000 + w * 32'h11;
    endfunction

    // ITCM macro: one-cycle read latency, byte writes at the grant edge.
    logic [31:0] mem [MemWords];
    logic [31:0] mem_rd_q;
    assign bus.mem_rdata = mem_rd_q;

    initial begin
        mem_rd_q = '0;
        for (int i = 0; i < int'(MemWords); i++) mem[i] = preload(i);
        forever begin
            @(posedge clk);
            if (bus.mem_en) begin
                if (bus.mem_we != 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
                end else begin
                    mem_rd_q <= mem[bus.mem_addr];
                end
            end
        end
    end

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [31:0] ref_mem [MemWords];
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int unsigned m_wait;    // consecutive cycles the current fetch has been refused
    logic [31:0] m_rexp;
    bit          last_if_gnt, last_d_gnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the next edge.
    task automatic check_cycle();
        bit            e_if, e_d, starve;
        logic [AW-3:0] e_addr;
        starve = StarveEn && (m_wait >= StarveMax);
        e_if   = rst_n && bus.if_req && (!bus.d_req || starve);
        e_d    = rst_n && bus.d_req && !e_if;
        e_addr = e_d ? bus.d_addr[AW-1:2] : bus.if_addr[AW-1:2];
        check("if_gnt", 32'(bus.if_gnt), 32'(e_if));
        check("d_gnt", 32'(bus.d_gnt), 32'(e_d));
        check("mem_en", 32'(bus.mem_en), 32'(e_if | e_d));
        check("mem_we", 32'(bus.mem_we), (e_d && bus.d_we) ? 32'(bus.d_be) : 32'd0);
        if (e_if || e_d) check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        if (e_d && bus.d_we) check("mem_wdata", bus.mem_wdata, bus.d_wdata);
        check("if_rvalid", 32'(bus.if_rvalid), 32'(m_owner == 1));
        check("d_rvalid", 32'(bus.d_rvalid), 32'(m_owner == 2));
        if (m_owner == 1) check("if_rdata", bus.if_rdata, m_rexp);
        if (m_owner == 2) check("d_rdata", bus.d_rdata, m_rexp);

        m_owner = 0;
        if (!rst_n) begin
            m_wait = 0;
        end else begin
            if (e_if) begin
                m_owner = 1;
                m_rexp  = ref_mem[bus.if_addr[AW-1:2]];
            end else if (e_d && !bus.d_we) begin
                m_owner = 2;
                m_rexp  = ref_mem[bus.d_addr[AW-1:2]];
            end else if (e_d) begin
                for (int b = 0; b < 4; b++)
                    if (bus.d_be[b]) ref_mem[bus.d_addr[AW-1:2]][8*b +: 8] = bus.d_wdata[8*b +: 8];
            end
            if (bus.if_req && !e_if) m_wait = (m_wait < StarveMax) ? m_wait + 1 : m_wait;
            else m_wait = 0;
        end
        last_if_gnt = e_if;
        last_d_gnt  = e_d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
        check_cycle();
    endtask

    task automatic drive(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                         input logic [3:0] be, input logic [AW-1:0] da, input logic [31:0] wd);
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_be    = be;
        bus.d_addr  = da;
        bus.d_wdata = wd;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
    endfunction

    initial begin
        int first_if;
        int if_grants;
        for (int i = 0; i < int'(MemWords); i++) ref_mem[i] = preload(i);
        m_owner = 0; m_wait = 0; m_rexp = '0; last_if_gnt = 0; last_d_gnt = 0;

        // Reset with both requesters active.
        rst_n = 1'b0;
        drive(1, 16'h0, 1, 0, 4'h0, 16'h100, 32'h0);
        #2;
        check("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
        check("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        check("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        check_cycle();
        tick(); settle();

        // Release with fetch only: addresses 0x0, 0x4, 0x8.
        tick(); rst_n = 1'b1; drive(1, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0); settle();
        check("rel_if_gnt", 32'(bus.if_gnt), 32'd1);
        check("f0_mem_addr", 32'(bus.mem_addr), 32'd0);
        tick(); drive(1, 16'h4, 0, 0, 4'h0, 16'h0, 32'h0); settle();
        check("f1_mem_addr", 32'(bus.mem_addr), 32'd1);
        check("f0_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("f0_rdata", bus.if_rdata, 32'h1000_0000);
        tick(); drive(1, 16'h8, 0, 0, 4'h0, 16'h0, 32'h0); settle();
        check("f2_mem_addr", 32'(bus.mem_addr), 32'd2);
        check("f1_rdata", bus.if_rdata, 32'h1000_0011);
        tick(); drive(0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0); settle();
        check("f2_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("f2_rdata", bus.if_rdata, 32'h1000_0022);

        // Contention: data read wins, fetch follows next cycle.
        tick(); drive(1, 16'hC, 1, 0, 4'h0, 16'h100, 32'h0); settle();
        check("ct_d_gnt", 32'(bus.d_gnt), 32'd1);
        check("ct_if_gnt", 32'(bus.if_gnt), 32'd0);
        check("ct_mem_addr", 32'(bus.mem_addr), 32'h40);
        tick(); drive(1, 16'hC, 0, 0, 4'h0, 16'h0, 32'h0); settle();
        check("ct_if_gnt2", 32'(bus.if_gnt), 32'd1);
        check("ct_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        check("ct_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        check("ct_d_rdata", bus.d_rdata, 32'h1000_0440);
        tick(); drive(0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0); settle();
        check("ct_if_rvalid2", 32'(bus.if_rvalid), 32'd1);
        check("ct_d_rvalid2", 32'(bus.d_rvalid), 32'd0);
        check("ct_if_rdata", bus.if_rdata, 32'h1000_0033);

        // Byte write then read-back of the same word.
        tick(); drive(0, 16'h0, 1, 1, 4'b0010, 16'h140, 32'hAABB_CCDD); settle();
        check("bw_mem_we", 32'(bus.mem_we), 32'h2);
        tick(); drive(0, 16'h0, 1, 0, 4'h0, 16'h140, 32'h0); settle();
        check("bw_rd_gnt", 32'(bus.d_gnt), 32'd1);
        check("bw_rd_early", 32'(bus.d_rvalid), 32'd0);
        tick(); drive(0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0); settle();
        check("bw_rvalid", 32'(bus.d_rvalid), 32'd1);
        check("bw_rdata", bus.d_rdata, 32'h1122_CC44);

        // Starvation: both requesters held for 20 cycles.
        first_if = 0;
        if_grants = 0;
        for (int c = 1; c <= 20; c++) begin
            tick(); drive(1, 16'h20, 1, 0, 4'h0, 16'h100, 32'h0); settle();
            if (bus.if_gnt) begin
                if_grants++;
                if (first_if == 0) first_if = c;
            end
        end
        check("starve_first_if", 32'(first_if), 32'(ExpFirstIf));
        check("starve_if_grants", 32'(if_grants), 32'(ExpIfGrants));
        tick(); drive(0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0); settle();

        // Reset asserted while a data read is returning.
        tick(); drive(0, 16'h0, 1, 0, 4'h0, 16'h140, 32'h0); settle();
        check("mr_d_gnt", 32'(bus.d_gnt), 32'd1);
        @(posedge clk); #1;
        drive(0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
        #1;
        check("mr_rvalid_before", 32'(bus.d_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_rvalid_drop", 32'(bus.d_rvalid), 32'd0);
        m_owner = 0;
        m_wait  = 0;
        #2; check_cycle();
        tick(); settle();
        tick(); rst_n = 1'b1; settle();
        check("mr_no_spurious1", 32'(bus.d_rvalid), 32'd0);
        tick(); settle();
        check("mr_no_spurious2", 32'(bus.d_rvalid | bus.if_rvalid), 32'd0);

        // Random traffic obeying the hold-until-grant rule.
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!(bus.if_req && !last_if_gnt)) begin
                bus.if_req  = ($urandom_range(0, 99) < 60);
                bus.if_addr = rand_addr();
            end
            if (!(bus.d_req && !last_d_gnt)) begin
                bus.d_req   = ($urandom_range(0, 99) < 70);
                bus.d_we    = ($urandom_range(0, 99) < 35);
                bus.d_be    = 4'($urandom_range(0, 15));
                bus.d_addr  = rand_addr();
                bus.d_wdata = $urandom;
            end
            settle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
